// File: rtl/fpu_pkg.sv
// Shared types for the FPU multiplier arbiter: FSM encoding, multiplier
// error codes and the canonical quiet NaN returned on a watchdog expiry.
package fpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MRST  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RESP  = 3'd4
  } fpu_state_e;

  typedef enum logic [2:0] {
    ERR_NONE      = 3'b000,
    ERR_NAN       = 3'b001,
    ERR_OVERFLOW  = 3'b010,
    ERR_UNDERFLOW = 3'b011,
    ERR_DIV0      = 3'b100,
    ERR_TIMEOUT   = 3'b101
  } fpu_err_e;

  localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past last_grant
// and wraps modulo NREQ; outputs a one-hot grant plus its binary index.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [IW-1:0]   last_grant,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   grant_idx,
  output logic            grant_any
);

  int            cand;
  logic [IW-1:0] cand_idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand     = (int'(last_grant) + k) % NREQ;
      cand_idx = IW'(cand);
      if (!grant_any && req_valid[cand_idx]) begin
        grant_any       = 1'b1;
        grant[cand_idx] = 1'b1;
        grant_idx       = cand_idx;
      end
    end
  end

endmodule

// File: rtl/fpu_mul_arb.sv
// Shares one multiplier between NREQ requesters: one operation in flight,
// round-robin accept, multiplier reset/start sequencing and a watchdog.
module fpu_mul_arb
  import fpu_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*32-1:0] req_a,
  input  logic [NREQ*32-1:0] req_b,
  output logic [NREQ-1:0]   resp_valid,
  input  logic [NREQ-1:0]   resp_ready,
  output logic [31:0]       resp_z,
  output logic [2:0]        resp_err,
  output logic              busy,
  output logic              mul_rst,
  output logic              mul_start,
  output logic [31:0]       mul_a,
  output logic [31:0]       mul_b,
  input  logic [31:0]       mul_z,
  input  logic [2:0]        mul_err,
  input  logic              mul_done,
  output fpu_state_e        dbg_state
);

  // Handshakes: a request transfers on a cycle where req_valid[i] and
  // req_ready[i] are both high (ready only in IDLE, one bit at most); a
  // result transfers when resp_valid[owner] and resp_ready[owner] are high.

  localparam int         IW      = $clog2(NREQ);
  // The watchdog register reaches TIMEOUT-1 on the same edge that enters RESP.
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 2);

  fpu_state_e      state, state_nx;
  logic [IW-1:0]   last_grant;
  logic [IW-1:0]   owner;
  logic [IW-1:0]   grant_idx;
  logic [NREQ-1:0] grant;
  logic            grant_any;
  logic [7:0]      wdog;
  logic            rst_q;
  logic            accept;
  logic            done_hit;
  logic            tmo_hit;

  rr_arbiter #(
    .NREQ(NREQ),
    .IW  (IW)
  ) u_arb (
    .req_valid (req_valid),
    .last_grant(last_grant),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign accept    = (state == ST_IDLE) && grant_any && !rst;
  assign done_hit  = (state == ST_WAIT) && mul_done;
  assign tmo_hit   = (state == ST_WAIT) && !mul_done && (wdog == WD_LAST);
  assign busy      = (state != ST_IDLE);
  assign mul_rst   = rst || rst_q || (state == ST_MRST);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      rst_q <= 1'b1;
    end else begin
      state <= state_nx;
      rst_q <= 1'b0;
    end
  end

  always_comb begin
    state_nx   = state;
    req_ready  = '0;
    resp_valid = '0;
    mul_start  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (grant_any && !rst) begin
          req_ready = grant;
          state_nx  = ST_MRST;
        end
      end
      ST_MRST:  state_nx = ST_ISSUE;
      ST_ISSUE: begin
        mul_start = 1'b1;
        state_nx  = ST_WAIT;
      end
      ST_WAIT: begin
        if (done_hit || tmo_hit) state_nx = ST_RESP;
      end
      ST_RESP: begin
        resp_valid[owner] = 1'b1;
        if (resp_ready[owner]) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= IW'(NREQ - 1);
      owner      <= '0;
      mul_a      <= '0;
      mul_b      <= '0;
      wdog       <= '0;
      resp_z     <= '0;
      resp_err   <= '0;
    end else begin
      if (accept) begin
        last_grant <= grant_idx;
        owner      <= grant_idx;
        mul_a      <= req_a[32*grant_idx +: 32];
        mul_b      <= req_b[32*grant_idx +: 32];
      end
      if (state == ST_ISSUE) begin
        wdog <= '0;
      end else if (state == ST_WAIT) begin
        wdog <= wdog + 8'd1;
      end
      // A completion in the expiry cycle takes priority over the timeout.
      if (done_hit) begin
        resp_z   <= mul_z;
        resp_err <= mul_err;
      end else if (tmo_hit) begin
        resp_z   <= CANON_NAN;
        resp_err <= ERR_TIMEOUT;
      end
    end
  end

endmodule

// File: tb/tb_fpu_mul_arb.sv
// Bench for fpu_mul_arb: behavioural multiplier, per-requester operand
// tables, and a scoreboard of {owner, err, z} checked on each result transfer.
module tb_fpu_mul_arb;
  import fpu_pkg::*;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 128;
  localparam int DEPTH   = 16;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [NREQ-1:0]    req_valid = '0;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*32-1:0] req_a = '0;
  logic [NREQ*32-1:0] req_b = '0;
  logic [NREQ-1:0]    resp_valid;
  logic [NREQ-1:0]    resp_ready = '1;
  logic [31:0]        resp_z;
  logic [2:0]         resp_err;
  logic               busy, mul_rst, mul_start;
  logic [31:0]        mul_a, mul_b;
  logic [31:0]        mul_z = '0;
  logic [2:0]         mul_err = '0;
  logic               mul_done = 1'b0;
  fpu_state_e         dbg_state;

  fpu_mul_arb #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_z(resp_z), .resp_err(resp_err),
    .busy(busy), .mul_rst(mul_rst), .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_z(mul_z), .mul_err(mul_err), .mul_done(mul_done), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  initial begin
    #400000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

  // ---------------- reference single-precision multiply {err, z}
  function automatic logic [34:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    int          e;
    logic [47:0] p;
    logic [22:0] m;
    s = a[31] ^ b[31];
    if ((a[30:23] == 8'hFF && a[22:0] != 0) || (b[30:23] == 8'hFF && b[22:0] != 0))
      return {3'b001, 32'hFFC0_0000};
    if (a[30:23] == 8'h00 || b[30:23] == 8'h00) return {3'b000, s, 31'd0};
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin
      e++;
      m = p[46:24];
    end else begin
      m = p[45:23];
    end
    if (e >= 255) return {3'b010, s, 8'hFF, 23'd0};
    if (e <= 0) return {3'b011, s, 31'd0};
    return {3'b000, s, e[7:0], m};
  endfunction

  function automatic logic [31:0] rnd_fp();
    return {1'($urandom_range(0, 1)), 8'($urandom_range(100, 150)), 23'($urandom_range(0, 23'h7FFFFF))};
  endfunction

  // ---------------- behavioural multiplier
  int          mul_lat  = 2;
  bit          mul_hang = 1'b0;
  bit          m_busy   = 1'b0;
  int          m_cnt    = 0;
  logic [34:0] m_res    = '0;

  always @(posedge clk) begin
    mul_done <= 1'b0;
    if (mul_rst) begin
      m_busy <= 1'b0;
    end else if (mul_start) begin
      m_busy <= 1'b1;
      m_cnt  <= mul_lat;
      m_res  <= fp_mul(mul_a, mul_b);
    end else if (m_busy && !mul_hang) begin
      if (m_cnt <= 1) begin
        mul_done           <= 1'b1;
        {mul_err, mul_z}   <= m_res;
        m_busy             <= 1'b0;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  // ---------------- requester drivers (operand tables per requester)
  logic [31:0] op_a   [NREQ][DEPTH];
  logic [31:0] op_b   [NREQ][DEPTH];
  logic [31:0] op_z   [NREQ][DEPTH];
  logic [2:0]  op_err [NREQ][DEPTH];
  int          head   [NREQ];
  int          tail   [NREQ];
  bit          acc_last [NREQ];
  logic [36:0] exp_q [$];
  logic [1:0]  grant_q [$];

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      head[i] = 0;
      tail[i] = 0;
      acc_last[i] = 1'b0;
    end
  end

  task automatic push_op(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] z, input logic [2:0] err);
    op_a[i][tail[i] % DEPTH]   = a;
    op_b[i][tail[i] % DEPTH]   = b;
    op_z[i][tail[i] % DEPTH]   = z;
    op_err[i][tail[i] % DEPTH] = err;
    tail[i]++;
  endtask

  task automatic push_rnd(input int i);
    logic [31:0] a, b;
    logic [34:0] r;
    a = rnd_fp();
    b = rnd_fp();
    r = fp_mul(a, b);
    push_op(i, a, b, r[31:0], r[34:32]);
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (acc_last[i]) begin
        head[i]++;
        acc_last[i] = 1'b0;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (head[i] != tail[i]) begin
        req_valid[i]      = 1'b1;
        req_a[32*i +: 32] = op_a[i][head[i] % DEPTH];
        req_b[32*i +: 32] = op_b[i][head[i] % DEPTH];
      end else begin
        req_valid[i]      = 1'b0;
        req_a[32*i +: 32] = '0;
        req_b[32*i +: 32] = '0;
      end
    end
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        acc_last[i] = 1'b1;
        grant_q.push_back(2'(i));
        exp_q.push_back({2'(i), op_err[i][head[i] % DEPTH], op_z[i][head[i] % DEPTH]});
      end
    end
  end

  // ---------------- scoreboard / monitor
  always @(negedge clk) begin
    logic [36:0] e;
    #2;
    if (!rst) begin
      if (req_ready != '0) begin
        n_checks++;
        if (!$onehot(req_ready) || dbg_state != ST_IDLE) begin
          n_fail++;
          $display("FAIL req_ready_rule got=%b state=%0d exp=onehot_in_idle", req_ready, dbg_state);
        end
      end
      if (resp_valid != '0) begin
        n_checks++;
        if (!$onehot(resp_valid)) begin
          n_fail++;
          $display("FAIL resp_valid_onehot got=%b exp=onehot", resp_valid);
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        if (resp_valid[i] && resp_ready[i]) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_resp got=owner%0d z=%h exp=none", i, resp_z);
          end else begin
            e = exp_q.pop_front();
            if ({2'(i), resp_err, resp_z} !== e) begin
              n_fail++;
              $display("FAIL resp_data got=owner%0d err=%b z=%h exp=owner%0d err=%b z=%h",
                       i, resp_err, resp_z, e[36:35], e[34:32], e[31:0]);
            end
          end
        end
      end
    end
  end

  // ---------------- helpers
  task automatic step();
    @(negedge clk);
    #3;
  endtask

  task automatic wait_state(input fpu_state_e s, input int budget, input string name, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      step();
      if (dbg_state == s) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_wait got=state%0d exp=state%0d", name, dbg_state, s);
    end
  endtask

  task automatic count_to_resp(input int idx, input int budget, output int n);
    n = 0;
    while (!resp_valid[idx] && n < budget) begin
      step();
      n++;
    end
  endtask

  task automatic wait_drain(input int budget, input string name);
    bit done;
    done = 1'b0;
    for (int k = 0; k < budget && !done; k++) begin
      step();
      done = (exp_q.size() == 0) && (dbg_state == ST_IDLE);
      for (int i = 0; i < NREQ; i++) if (head[i] != tail[i]) done = 1'b0;
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s_drain got=pending%0d exp=pending0", name, exp_q.size());
    end
  endtask

  // ---------------- scenarios
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    n_checks++;
    if ({req_ready, resp_valid, busy, mul_start} !== '0) begin
      n_fail++;
      $display("FAIL reset_ctrl got=%b_%b_%b_%b exp=0", req_ready, resp_valid, busy, mul_start);
    end
    n_checks++;
    if ({mul_a, mul_b, resp_z, resp_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_data got=%h_%h_%h_%b exp=0", mul_a, mul_b, resp_z, resp_err);
    end
    n_checks++;
    if (mul_rst !== 1'b1 || dbg_state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL reset_mulrst got=%b state=%0d exp=1 state0", mul_rst, dbg_state);
    end
    @(negedge clk);
    rst = 1'b0;
    #3;
    n_checks++;
    if (mul_rst !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mulrst_after got=%b exp=1", mul_rst);
    end
    step();
    n_checks++;
    if (mul_rst !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release got=mul_rst%b busy%b exp=00", mul_rst, busy);
    end
  endtask

  task automatic test_single();
    bit ok;
    int n;
    mul_lat = 3;
    push_op(0, 32'hC128_0000, 32'h4020_0000, 32'hC1D2_0000, 3'b000);
    wait_state(ST_ISSUE, 20, "single", ok);
    count_to_resp(0, 50, n);
    n_checks++;
    if (n != 2 + mul_lat) begin
      n_fail++;
      $display("FAIL single_latency got=%0d exp=%0d", n, 2 + mul_lat);
    end
    wait_drain(50, "single");
  endtask

  task automatic test_round_robin();
    rst = 1'b1;
    step();
    step();
    grant_q.delete();
    mul_lat = $urandom_range(1, 5);
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NREQ; i++) push_rnd(i);
    @(negedge clk);
    rst = 1'b0;
    wait_drain(400, "rr");
    n_checks++;
    if (grant_q.size() != 2 * NREQ) begin
      n_fail++;
      $display("FAIL rr_count got=%0d exp=%0d", grant_q.size(), 2 * NREQ);
    end
    for (int k = 0; k < grant_q.size() && k < 2 * NREQ; k++) begin
      n_checks++;
      if (int'(grant_q[k]) != k % NREQ) begin
        n_fail++;
        $display("FAIL rr_order[%0d] got=%0d exp=%0d", k, grant_q[k], k % NREQ);
      end
    end
  endtask

  task automatic test_hold_ready();
    bit ok;
    int n;
    logic [31:0] z0;
    logic [2:0]  e0;
    mul_lat = 2;
    resp_ready = 4'b1101;
    push_rnd(1);
    push_rnd(2);
    count_to_resp(1, 60, n);
    n_checks++;
    if (!resp_valid[1]) begin
      n_fail++;
      $display("FAIL hold_resp_wait got=%b exp=0010", resp_valid);
    end
    z0 = resp_z;
    e0 = resp_err;
    for (int k = 0; k < 10; k++) begin
      step();
      n_checks++;
      if (resp_valid !== 4'b0010 || resp_z !== z0 || resp_err !== e0 || req_ready !== '0 || dbg_state !== ST_RESP) begin
        n_fail++;
        $display("FAIL hold_stable[%0d] got=v%b z%h e%b r%b exp=v0010 z%h e%b r0000",
                 k, resp_valid, resp_z, resp_err, req_ready, z0, e0);
      end
    end
    @(negedge clk);
    resp_ready = 4'b1111;
    #3;
    step();
    n_checks++;
    if (dbg_state !== ST_IDLE || req_ready !== 4'b0100) begin
      n_fail++;
      $display("FAIL hold_release got=state%0d ready%b exp=state0 ready0100", dbg_state, req_ready);
    end
    wait_drain(60, "hold");
    ok = 1'b1;
  endtask

  task automatic test_nan();
    mul_lat = $urandom_range(1, 4);
    push_op(2, 32'h7FC0_0000, 32'h3F80_0000, 32'hFFC0_0000, 3'b001);
    push_rnd(0);
    push_rnd(3);
    wait_drain(100, "nan");
  endtask

  task automatic test_timeout();
    bit ok;
    int n;
    mul_hang = 1'b1;
    push_op(3, rnd_fp(), rnd_fp(), CANON_NAN, ERR_TIMEOUT);
    wait_state(ST_ISSUE, 20, "timeout", ok);
    count_to_resp(3, TIMEOUT + 20, n);
    n_checks++;
    if (n != TIMEOUT) begin
      n_fail++;
      $display("FAIL timeout_latency got=%0d exp=%0d", n, TIMEOUT);
    end
    wait_drain(20, "timeout");
    mul_hang = 1'b0;
    mul_lat = 3;
    push_rnd(3);
    wait_drain(40, "after_timeout");
  endtask

  task automatic test_reset_mid();
    bit ok;
    mul_lat = 20;
    push_rnd(2);
    wait_state(ST_WAIT, 20, "rstmid", ok);
    step();
    step();
    rst = 1'b1;
    exp_q.delete();
    step();
    step();
    n_checks++;
    if ({resp_valid, busy, mul_start, req_ready} !== '0 || mul_rst !== 1'b1 || dbg_state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL rstmid_ctrl got=v%b b%b s%b r%b m%b state%0d exp=0 mul_rst1 state0",
               resp_valid, busy, mul_start, req_ready, mul_rst, dbg_state);
    end
    n_checks++;
    if ({mul_a, mul_b, resp_z, resp_err} !== '0) begin
      n_fail++;
      $display("FAIL rstmid_data got=%h_%h_%h_%b exp=0", mul_a, mul_b, resp_z, resp_err);
    end
    mul_lat = 2;
    grant_q.delete();
    push_rnd(1);
    push_rnd(3);
    step();
    n_checks++;
    if (req_ready !== '0) begin
      n_fail++;
      $display("FAIL rstmid_ready got=%b exp=0000", req_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    wait_drain(100, "rstmid");
    n_checks++;
    if (grant_q.size() != 2 || grant_q[0] != 2'd1 || grant_q[1] != 2'd3) begin
      n_fail++;
      $display("FAIL rstmid_order got=size%0d first%0d exp=size2 first1", grant_q.size(),
               (grant_q.size() > 0) ? int'(grant_q[0]) : -1);
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 6; k++) push_rnd($urandom_range(0, NREQ - 1));
    mul_lat = $urandom_range(1, 6);
    wait_drain(300, "b2b");
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_hold_ready();
    test_nan();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fpu_mul_arb.md
FPU_MUL_ARB -- requirements
Module: fpu_mul_arb

Interface
REQ-001 Parameter NREQ, default 4: number of requesters, range 2..8.
REQ-002 Parameter TIMEOUT, default 128: watchdog limit in clk cycles per operation, range 16..255.
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  NREQ  per-requester operation request.
REQ-006 req_ready  output  NREQ  per-requester accept; at most one bit high.
REQ-007 req_a, req_b  input  NREQ*32 each  IEEE-754 single operands; slice i = bits [32i+31:32i].
REQ-008 resp_valid  output  NREQ  one-hot result-valid to the owning requester.
REQ-009 resp_ready  input  NREQ  per-requester result accept.
REQ-010 resp_z  output  32  result word; resp_err  output  3  error code.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 mul_rst, mul_start  output  1 each  reset and start to the shared multiplier.
REQ-013 mul_a, mul_b  output  32 each  operands to the multiplier, registered.
REQ-014 mul_z  input  32; mul_err  input  3; mul_done  input  1  multiplier result, error code and completion.

Function
REQ-015 FSM states: IDLE, MRST, ISSUE, WAIT, RESP.
REQ-016 IDLE: if any req_valid, the round-robin winner gets req_ready for that cycle only; next cycle MRST.
REQ-017 Round-robin: search starts at last_grant+1 modulo NREQ; last_grant updates on every accept.
REQ-018 On accept: capture req_a/req_b of the winner into mul_a/mul_b and its index into owner; values held until the next accept.
REQ-019 MRST: mul_rst=1 for exactly one cycle; next state ISSUE.
REQ-020 ISSUE: mul_start=1 for exactly one cycle; watchdog cleared to 0; next state WAIT.
REQ-021 WAIT: mul_start=0; watchdog increments each cycle; mul_done is sampled only in WAIT.
REQ-022 WAIT, mul_done=1: capture mul_z into resp_z and mul_err into resp_err; go to RESP.
REQ-023 WAIT, watchdog reaching TIMEOUT-1 without mul_done: resp_z=32'h7FC00000, resp_err=3'b101 (TIMEOUT); go to RESP.
REQ-024 If mul_done and the timeout hit occur in the same cycle, mul_done wins.
REQ-025 RESP: resp_valid[owner]=1; all other bits 0. resp_z and resp_err hold stable.
REQ-026 RESP with resp_ready[owner]=1: result transfers in that cycle; next state IDLE.
REQ-027 resp_ready bits of non-owners are ignored.
REQ-028 No req_ready is asserted outside IDLE; new requests wait, with no loss or reordering per requester.
REQ-029 Latency from accept to resp_valid: 3 + multiplier cycles (minimum 4).
REQ-030 Single outstanding operation; no pipelining across the shared multiplier.

Reset
REQ-031 While rst=1, next-cycle values are: state IDLE, req_ready 0, resp_valid 0, resp_z 0, resp_err 0, busy 0, mul_start 0, mul_a/mul_b 0, watchdog 0, owner 0, last_grant NREQ-1.
REQ-032 mul_rst is 1 during rst and for the first cycle after rst deasserts.
REQ-033 rst mid-operation in any state aborts the operation with no response; the aborted request is not retried automatically.

Structure
REQ-034 Package fpu_pkg holds:
- error codes NoError 000, NaN 001, Overflow 010, Underflow 011, DivideBy0 100, Timeout 101;
- FSM state encoding;
- canonical NaN constant 32'h7FC00000.
REQ-035 Sub-module rr_arbiter: combinational round-robin grant from req_valid and last_grant, producing a one-hot grant and a binary index.

Verification
REQ-036 Single request, requester 0, a=32'hC1280000, b=32'h40200000, real multiplier: resp_valid[0] with resp_z=32'hC1D20000 and resp_err=000.
REQ-037 All four requesters valid from the first cycle after reset: grants in order 0, 1, 2, 3, then 0 again if still valid; each resp_valid bit matches its owner.
REQ-038 resp_ready[owner] held low for 10 cycles in RESP: resp_valid, resp_z and resp_err stable; no req_ready asserted; IDLE is entered the cycle after resp_ready rises.
REQ-039 a=32'h7FC00000, b=32'h3F800000: resp_z=32'hFFC00000, resp_err=001.
REQ-040 Behavioural multiplier holding mul_done=0: resp_valid rises TIMEOUT cycles after ISSUE, with resp_z=32'h7FC00000 and resp_err=101; the next request proceeds normally.
REQ-041 rst pulsed during WAIT: all outputs take REQ-031 values, mul_rst=1, no response issued, and the next request is granted from index 0.
